// File: rtl/mem_bus_arbiter.sv
// Arbiter that shares the single-port Cache RAM between instruction fetch and the data bus.
// One transaction in flight: IDLE (sample) -> ACCESS (grant + strobes) -> RESP (rvalid + data).
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W   = 11,
  parameter logic [31:0] ROM_BASE = 32'h0000_0000,
  parameter logic [31:0] ROM_SIZE = 32'h0000_1000,
  parameter logic [31:0] RAM_BASE = 32'h0000_1000,
  parameter logic [31:0] RAM_SIZE = 32'h0000_1000,
  parameter logic [31:0] ART_BASE = 32'h0000_FFFF,
  parameter logic [31:0] KEY_BASE = 32'h0000_FFFE,
  parameter logic [31:0] IF_FILL  = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [63:0]       d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [63:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              uart_wr_n,
  output logic [31:0]       uart_wdata,
  input  logic [7:0]        key_data
);

  localparam logic [63:0] L_ROM_BASE = {32'b0, ROM_BASE};
  localparam logic [63:0] L_ROM_SIZE = {32'b0, ROM_SIZE};
  localparam logic [63:0] L_RAM_BASE = {32'b0, RAM_BASE};
  localparam logic [63:0] L_RAM_SIZE = {32'b0, RAM_SIZE};
  localparam logic [63:0] L_ART_BASE = {32'b0, ART_BASE};
  localparam logic [63:0] L_KEY_BASE = {32'b0, KEY_BASE};
  localparam logic [63:0] L_DEAD     = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Access class resolved when the request is latched, so ACCESS/RESP only look at registers.
  typedef enum logic [2:0] {
    K_MEM  = 3'd0,
    K_UART = 3'd1,
    K_KEY  = 3'd2,
    K_ZERO = 3'd3,
    K_ERR  = 3'd4,
    K_OOR  = 3'd5,
    K_FILL = 3'd6
  } kind_t;

  // Subtract-and-compare also rejects addresses below the base through wraparound.
  function automatic logic in_rom(input logic [63:0] a);
    return (a - L_ROM_BASE) < L_ROM_SIZE;
  endfunction

  function automatic logic in_mem(input logic [63:0] a);
    return in_rom(a) || ((a - L_RAM_BASE) < L_RAM_SIZE);
  endfunction

  function automatic kind_t decode_d(input logic we, input logic [63:0] a);
    kind_t k;
    if (a == L_ART_BASE)          k = we ? K_UART : K_ZERO;
    else if (a == L_KEY_BASE)     k = we ? K_ZERO : K_KEY;
    else if (!in_mem(a))          k = K_OOR;
    else if (a[1:0] != 2'b00)     k = K_ERR;
    else if (we && in_rom(a))     k = K_ERR;
    else                          k = K_MEM;
    return k;
  endfunction

  function automatic kind_t decode_if(input logic [31:0] a);
    return in_mem({32'b0, a}) ? K_MEM : K_FILL;
  endfunction

  state_t            r_state;
  state_t            w_state_next;
  logic              r_rr_last_d;
  logic              r_sel_d;
  logic              r_we;
  logic [ADDR_W-1:0] r_widx;
  logic [31:0]       r_wdata;
  kind_t             r_kind;
  logic [7:0]        r_key;
  logic [31:0]       r_if_rdata;
  logic [63:0]       r_d_rdata;

  logic              w_take;
  logic              w_pick_d;
  logic [63:0]       w_sel_addr;
  kind_t             w_sel_kind;
  logic              w_access;
  logic              w_resp;
  logic              w_strobe_ok;
  logic              w_if_rvalid;
  logic              w_d_rvalid;
  logic [31:0]       w_if_rdata_resp;
  logic [63:0]       w_d_rdata_resp;
  logic              w_unused_ok;

  assign w_unused_ok = &{1'b0, d_wdata[63:32]};

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_pick_d     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (d_req || if_req) begin
          w_take       = 1'b1;
          w_pick_d     = d_req && (!if_req || !r_rr_last_d);
          w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: w_state_next = S_RESP;
      default:  w_state_next = S_IDLE;
    endcase
  end

  assign w_sel_addr = w_pick_d ? d_addr : {32'b0, if_addr};
  assign w_sel_kind = w_pick_d ? decode_d(d_we, d_addr) : decode_if(if_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_last_d <= 1'b0;
      r_sel_d     <= 1'b0;
      r_we        <= 1'b0;
      r_widx      <= '0;
      r_wdata     <= '0;
      r_kind      <= K_FILL;
      r_key       <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_sel_d <= w_pick_d;
        r_we    <= w_pick_d & d_we;
        r_widx  <= w_sel_addr[ADDR_W+1:2];
        r_wdata <= w_pick_d ? d_wdata[31:0] : 32'b0;
        r_kind  <= w_sel_kind;
      end
      if (w_access) begin
        r_rr_last_d <= r_sel_d;
        if (r_kind == K_KEY) r_key <= key_data;
      end
      if (w_if_rvalid) r_if_rdata <= w_if_rdata_resp;
      if (w_d_rvalid)  r_d_rdata  <= w_d_rdata_resp;
    end
  end

  assign w_access = (r_state == S_ACCESS);
  assign w_resp   = (r_state == S_RESP);
  // Side-effect strobes are suppressed in the cycle reset is sampled so an aborted write never lands.
  assign w_strobe_ok = w_access & ~reset;

  assign if_gnt      = w_access & ~r_sel_d;
  assign d_gnt       = w_access &  r_sel_d;
  assign w_if_rvalid = w_resp & ~r_sel_d;
  assign w_d_rvalid  = w_resp &  r_sel_d;
  assign if_rvalid   = w_if_rvalid;
  assign d_rvalid    = w_d_rvalid;

  assign mem_en     = w_strobe_ok & (r_kind == K_MEM);
  assign mem_we     = mem_en & r_we;
  assign mem_addr   = r_widx;
  assign mem_wdata  = r_wdata;
  assign uart_wr_n  = ~(w_strobe_ok & (r_kind == K_UART));
  assign uart_wdata = r_wdata;

  assign w_if_rdata_resp = (r_kind == K_MEM) ? mem_rdata : IF_FILL;

  always_comb begin
    w_d_rdata_resp = 64'b0;
    case (r_kind)
      K_MEM:   w_d_rdata_resp = r_we ? 64'b0 : {32'b0, mem_rdata};
      K_KEY:   w_d_rdata_resp = {56'b0, r_key};
      K_OOR:   w_d_rdata_resp = L_DEAD;
      default: w_d_rdata_resp = 64'b0;
    endcase
  end

  assign if_rdata = w_if_rvalid ? w_if_rdata_resp : r_if_rdata;
  assign d_rdata  = w_d_rvalid  ? w_d_rdata_resp  : r_d_rdata;
  assign d_err    = w_d_rvalid & ((r_kind == K_ERR) || (r_kind == K_OOR));

endmodule
